// File: rtl/bram_burst_arbiter_if.sv
// Requester-side bundle of the BRAM burst arbiter: packed burst requests in,
// acceptance pulses and routed read responses out.
interface bram_burst_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 8
);
  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len_m1;
  logic [NUM_REQ-1:0]            req_rdy;
  logic [NUM_REQ-1:0]            rsp_vld;
  logic [NUM_REQ-1:0]            rsp_last;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_vld, req_base, req_len_m1,
    input  req_rdy, rsp_vld, rsp_last, rsp_data
  );

  modport slave (
    input  req_vld, req_base, req_len_m1,
    output req_rdy, rsp_vld, rsp_last, rsp_data
  );
endinterface

// File: rtl/bram_burst_arbiter.sv
// Round-robin burst read arbiter sharing one BRAM read port among NUM_REQ requesters.
// Optional saturating stat counters (stat_words, stat_wait) under BRAM_ARB_STATS_EN.
module bram_burst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_burst_arbiter_if.slave   rif,
  output logic                  busy,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  input  logic                  bram_rd_data_vld
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_wait
`endif
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      cand;
  logic                  gnt_found;
  logic [ADDR_WIDTH-1:0] gnt_base;
  logic [LEN_WIDTH-1:0]  gnt_len_m1;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [IDX_W-1:0]      owner_q;
  logic                  last_q;
  logic                  issued_q;
  logic [NUM_REQ-1:0]    req_rdy;
  logic [NUM_REQ-1:0]    rsp_vld;
  logic [NUM_REQ-1:0]    rsp_last;

  // Rotating priority search, starting just above the previous winner.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    cand       = '0;
    gnt_base   = '0;
    gnt_len_m1 = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!gnt_found && rif.req_vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        gnt_base   = rif.req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_len_m1 = rif.req_len_m1[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
    req_rdy = '0;
    if (state == IDLE && gnt_found) req_rdy[gnt_idx] = 1'b1;
  end

  // Arbitration / issue FSM; response-tracking registers follow the issue stage by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cur_addr   <= '0;
      remaining  <= '0;
      owner_q    <= '0;
      last_q     <= 1'b0;
      issued_q   <= 1'b0;
    end else begin
      issued_q <= bram_re;
      owner_q  <= last_grant;
      last_q   <= (remaining == '0);
      case (state)
        IDLE: begin
          if (gnt_found) begin
            cur_addr   <= gnt_base;
            remaining  <= gnt_len_m1;
            last_grant <= gnt_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cur_addr  <= (cur_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : cur_addr + ADDR_WIDTH'(1);
          remaining <= remaining - LEN_WIDTH'(1);
          if (remaining == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state == ISSUE);
  assign bram_re      = busy;
  assign bram_rd_addr = cur_addr;

  always_comb begin
    rsp_vld  = '0;
    rsp_last = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_vld[i]  = issued_q & bram_rd_data_vld & (owner_q == IDX_W'(i));
      rsp_last[i] = rsp_vld[i] & last_q;
    end
  end

  assign rif.req_rdy  = req_rdy;
  assign rif.rsp_vld  = rsp_vld;
  assign rif.rsp_last = rsp_last;
  assign rif.rsp_data = bram_rd_data;

`ifdef BRAM_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words <= '0;
      stat_wait  <= '0;
    end else begin
      if (|rsp_vld) stat_words <= sat_inc(stat_words);
      if ((|rif.req_vld) && !(|req_rdy)) stat_wait <= sat_inc(stat_wait);
    end
  end
`endif
endmodule

// File: tb/tb_bram_burst_arbiter.sv
// Directed bench for bram_burst_arbiter with a 1-cycle-latency BRAM model.
// Stat counter checks are compiled in when BRAM_ARB_STATS_EN is defined.
module tb_bram_burst_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DP = 256;
  localparam int DW = 256;
  localparam int LW = 8;

  logic          clk;
  logic          rst_n;
  logic          busy;
  logic          bram_re;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data;
  logic          bram_rd_data_vld;
`ifdef BRAM_ARB_STATS_EN
  logic [31:0]   stat_words;
  logic [31:0]   stat_wait;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [DP];

  bram_burst_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) rif ();

  bram_burst_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DEPTH(DP), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rif              (rif),
    .busy             (busy),
    .bram_re          (bram_re),
    .bram_rd_addr     (bram_rd_addr),
    .bram_rd_data     (bram_rd_data),
    .bram_rd_data_vld (bram_rd_data_vld)
`ifdef BRAM_ARB_STATS_EN
    ,
    .stat_words       (stat_words),
    .stat_wait        (stat_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input int a);
    return {8{32'hA500_0000 | 32'(a)}} ^ {32'(a) * 32'h0101_0101, 224'h0};
  endfunction

  function automatic logic [255:0] oh(input int i);
    return 256'(1) << i;
  endfunction

  // BRAM model: one-cycle registered read, valid not reset.
  always @(posedge clk) begin
    bram_rd_data_vld <= bram_re;
    bram_rd_data     <= mem[bram_rd_addr];
  end

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int r, input int base, input int len_m1);
    rif.req_base[r*AW +: AW]   = AW'(base);
    rif.req_len_m1[r*LW +: LW] = LW'(len_m1);
    rif.req_vld[r]             = 1'b1;
  endtask

  task automatic run_burst(input int r, input int base, input int len_m1, input string tag);
    int a;
    int prev;
    int wt;
    @(posedge clk); #1;
    set_req(r, base, len_m1);
    @(negedge clk);
    wt = 0;
    while (rif.req_rdy == '0 && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check_eq({tag, "_rdy"}, 256'(rif.req_rdy), oh(r));
    @(posedge clk); #1;
    rif.req_vld[r] = 1'b0;
    a    = base;
    prev = base;
    for (int i = 0; i <= len_m1; i++) begin
      @(negedge clk);
      check_eq({tag, "_addr"}, 256'(bram_rd_addr), 256'(a));
      check_eq({tag, "_re"}, 256'(bram_re), 256'(1));
      check_eq({tag, "_busy"}, 256'(busy), 256'(1));
      if (i > 0) begin
        check_eq({tag, "_rsp_vld"}, 256'(rif.rsp_vld), oh(r));
        check_eq({tag, "_rsp_last"}, 256'(rif.rsp_last), 256'(0));
        check_eq({tag, "_rsp_data"}, rif.rsp_data, mem_val(prev));
      end
      prev = a;
      a    = (a + 1) % DP;
    end
    @(negedge clk);
    check_eq({tag, "_end_busy"}, 256'(busy), 256'(0));
    check_eq({tag, "_end_re"}, 256'(bram_re), 256'(0));
    check_eq({tag, "_end_vld"}, 256'(rif.rsp_vld), oh(r));
    check_eq({tag, "_end_last"}, 256'(rif.rsp_last), oh(r));
    check_eq({tag, "_end_data"}, rif.rsp_data, mem_val(prev));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DP; i++) mem[i] = mem_val(i);
    rst_n          = 1'b0;
    rif.req_vld    = '0;
    rif.req_base   = '0;
    rif.req_len_m1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdy", 256'(rif.req_rdy), 256'(0));
    check_eq("rst_re", 256'(bram_re), 256'(0));
    check_eq("rst_addr", 256'(bram_rd_addr), 256'(0));
    check_eq("rst_vld", 256'(rif.rsp_vld), 256'(0));
    check_eq("rst_last", 256'(rif.rsp_last), 256'(0));
    check_eq("rst_busy", 256'(busy), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_burst(0, 10, 3, "single");
    run_burst(1, 254, 3, "wrap");
    run_burst(3, 0, 255, "maxlen");

    // All four requesters held from reset, single-word bursts.
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 16 * i, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("rr_rdy", 256'(rif.req_rdy), oh(k % 4));
      check_eq("rr_idle_busy", 256'(busy), 256'(0));
      if (k > 0) begin
        check_eq("rr_rsp_vld", 256'(rif.rsp_vld), oh((k - 1) % 4));
        check_eq("rr_rsp_last", 256'(rif.rsp_last), oh((k - 1) % 4));
        check_eq("rr_rsp_data", rif.rsp_data, mem_val(16 * ((k - 1) % 4)));
      end
      @(negedge clk);
      check_eq("rr_issue_busy", 256'(busy), 256'(1));
      check_eq("rr_issue_addr", 256'(bram_rd_addr), 256'(16 * (k % 4)));
      check_eq("rr_issue_rdy", 256'(rif.req_rdy), 256'(0));
    end
    @(posedge clk); #1;
    rif.req_vld = '0;

    // Reset during the third issue of an 8-word burst.
    @(posedge clk); #1;
    set_req(0, 100, 7);
    @(negedge clk);
    check_eq("mid_rdy", 256'(rif.req_rdy), oh(0));
    @(posedge clk); #1;
    rif.req_vld = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("mid_pre_addr", 256'(bram_rd_addr), 256'(102));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_re", 256'(bram_re), 256'(0));
    check_eq("mid_rst_addr", 256'(bram_rd_addr), 256'(0));
    check_eq("mid_rst_busy", 256'(busy), 256'(0));
    check_eq("mid_rst_vld", 256'(rif.rsp_vld), 256'(0));
    check_eq("mid_rst_last", 256'(rif.rsp_last), 256'(0));
    rst_n = 1'b1;
    set_req(2, 40, 0);
    set_req(3, 50, 0);
    @(negedge clk);
    check_eq("post_rst_vld", 256'(rif.rsp_vld), 256'(0));
    check_eq("post_rst_rdy", 256'(rif.req_rdy), oh(2));
    @(posedge clk); #1;
    rif.req_vld = '0;
    @(negedge clk);
    check_eq("post_rst_addr", 256'(bram_rd_addr), 256'(40));
    check_eq("post_rst_re", 256'(bram_re), 256'(1));
    @(negedge clk);
    check_eq("post_rst_rsp_vld", 256'(rif.rsp_vld), oh(2));
    check_eq("post_rst_rsp_last", 256'(rif.rsp_last), oh(2));
    check_eq("post_rst_rsp_data", rif.rsp_data, mem_val(40));

`ifdef BRAM_ARB_STATS_EN
    // Two contending 4-word bursts: req1 waits through req0's four issue cycles.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("stat_rst_words", 256'(stat_words), 256'(0));
    check_eq("stat_rst_wait", 256'(stat_wait), 256'(0));
    set_req(0, 0, 3);
    set_req(1, 8, 3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("stat_rdy0", 256'(rif.req_rdy), oh(0));
    @(posedge clk); #1;
    rif.req_vld[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("stat_rdy1", 256'(rif.req_rdy), oh(1));
    @(posedge clk); #1;
    rif.req_vld = '0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("stat_words", 256'(stat_words), 256'(8));
    check_eq("stat_wait", 256'(stat_wait), 256'(4));
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
